// File: rtl/ps2_receptor.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_receptor
//  Description : PS/2 keyboard frame receiver. Synchronises and glitch-filters
//                the PS/2 clock, samples data on each filtered falling edge,
//                assembles 11-bit frames (start, 8 data LSB-first, odd parity,
//                stop), checks them and delivers accepted scancodes with a
//                one-cycle strobe. Optionally swallows break sequences (F0 xx)
//                so only key presses reach the downstream control FSM.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FILTER_LEN   : samples ps2c must hold a new level before it is accepted
//                   (2..16)
//    TIMEOUT      : clk cycles without a ps2c falling edge mid-frame before
//                   the frame is aborted
//    FILTER_BREAK : 1 = swallow F0 and the byte following it
//  Ports
//    clk          in   1  system clock, all logic on posedge
//    rst          in   1  asynchronous, active-low reset
//    ps2c         in   1  PS/2 clock pin (asynchronous, idle high)
//    ps2d         in   1  PS/2 data pin (asynchronous, idle high)
//    dout         out  8  last accepted scancode, held until the next one
//    valida       out  1  one-cycle pulse: dout has just been updated
//    err_paridad  out  1  one-cycle pulse: frame rejected for bad odd parity
//    err_trama    out  1  one-cycle pulse: stop bit 0 or mid-frame timeout
//    ocupado      out  1  high while a frame is in progress
// ============================================================================
module ps2_receptor #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT      = 10000,
    parameter bit FILTER_BREAK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] dout,
    output logic       valida,
    output logic       err_paridad,
    output logic       err_trama,
    output logic       ocupado
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int FW = $clog2(FILTER_LEN);
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [3:0]    PAR_SLOT  = 4'd8;   // bit index holding parity
    localparam logic [7:0]    BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATOS = 2'd1,
        STOP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers (idle level is high, so they reset to 1)
    // ------------------------------------------------------------------------
    logic r_c_s1;
    logic r_c_s2;
    logic r_d_s1;
    logic r_d_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_s1 <= 1'b1;
            r_c_s2 <= 1'b1;
            r_d_s1 <= 1'b1;
            r_d_s2 <= 1'b1;
        end else begin
            r_c_s1 <= ps2c;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= ps2d;
            r_d_s2 <= r_d_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Glitch filter on the synchronised clock.
    // The counter runs only while the synced level disagrees with the filtered
    // level; any sample that agrees again restarts it, so a pulse shorter than
    // FILTER_LEN samples never reaches the filtered clock.
    // ------------------------------------------------------------------------
    logic [FW-1:0] r_filt_cnt;
    logic          r_ps2c_f;
    logic          r_ps2c_f_d;
    logic          w_bajada;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_cnt <= '0;
            r_ps2c_f   <= 1'b1;
            r_ps2c_f_d <= 1'b1;
        end else begin
            r_ps2c_f_d <= r_ps2c_f;
            if (r_c_s2 == r_ps2c_f) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_ps2c_f   <= r_c_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // One-cycle strobe on a 1->0 transition of the filtered clock.
    assign w_bajada = r_ps2c_f_d & ~r_ps2c_f;

    // ------------------------------------------------------------------------
    // Frame FSM with watchdog, checks and break suppression.
    // All outputs are registered here; the three pulses default low every
    // cycle, and each branch sets at most one of them.
    // ------------------------------------------------------------------------
    state_t        r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_sreg;
    logic          r_par;
    logic [WW-1:0] r_wd_cnt;
    logic          r_f0;
    logic          w_wd_expired;
    logic          w_par_ok;

    assign w_wd_expired = (r_wd_cnt == WD_LAST);
    // Odd parity: data plus parity bit must contain an odd number of ones.
    assign w_par_ok     = ^{r_sreg, r_par};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_sreg      <= '0;
            r_par       <= 1'b0;
            r_wd_cnt    <= '0;
            r_f0        <= 1'b0;
            dout        <= '0;
            valida      <= 1'b0;
            err_paridad <= 1'b0;
            err_trama   <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            valida      <= 1'b0;
            err_paridad <= 1'b0;
            err_trama   <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_wd_cnt <= '0;
                    // A falling edge with data high is line noise, not a start bit.
                    if (w_bajada && !r_d_s2) begin
                        r_state   <= DATOS;
                        r_bit_cnt <= '0;
                        ocupado   <= 1'b1;
                    end
                end

                DATOS: begin
                    if (w_bajada) begin
                        r_wd_cnt <= '0;
                        if (r_bit_cnt == PAR_SLOT) begin
                            r_par   <= r_d_s2;
                            r_state <= STOP;
                        end else begin
                            // LSB arrives first: shift in from the top.
                            r_sreg    <= {r_d_s2, r_sreg[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_wd_expired) begin
                        err_trama <= 1'b1;
                        r_state   <= IDLE;
                        ocupado   <= 1'b0;
                        r_wd_cnt  <= '0;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (w_bajada) begin
                        r_state  <= IDLE;
                        ocupado  <= 1'b0;
                        r_wd_cnt <= '0;
                        if (!r_d_s2) begin
                            err_trama <= 1'b1;
                        end else if (!w_par_ok) begin
                            err_paridad <= 1'b1;
                        end else if (FILTER_BREAK && (r_sreg == BREAK_CODE)) begin
                            // Release prefix: remember it, deliver nothing.
                            r_f0 <= 1'b1;
                        end else if (FILTER_BREAK && r_f0) begin
                            // Key code of a release: swallow it.
                            r_f0 <= 1'b0;
                        end else begin
                            dout   <= r_sreg;
                            valida <= 1'b1;
                        end
                    end else if (w_wd_expired) begin
                        err_trama <= 1'b1;
                        r_state   <= IDLE;
                        ocupado   <= 1'b0;
                        r_wd_cnt  <= '0;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    ocupado  <= 1'b0;
                    r_wd_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_receptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_receptor
//  Description : Directed self-checking bench for ps2_receptor. Drives PS/2
//                frames bit by bit and compares pulse counts, delivered
//                scancodes and pulse latency against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receptor;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 10000;
    localparam int HALF       = 60;   // clk cycles per PS/2 clock half period
    // 2 synchroniser flops + FILTER_LEN filter samples + 1 output register
    localparam int EXP_LAT    = 2 + FILTER_LEN + 1;

    logic       clk;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] dout;
    logic       valida;
    logic       err_paridad;
    logic       err_trama;
    logic       ocupado;

    int n_tests = 0;
    int n_fail  = 0;
    int n_val   = 0;
    int n_par   = 0;
    int n_tra   = 0;
    int n_multi = 0;
    int last_lat = 0;
    int ocup_mid = 0;
    logic [7:0] last_dout = '0;

    ps2_receptor #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT     (TIMEOUT),
        .FILTER_BREAK(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .dout       (dout),
        .valida     (valida),
        .err_paridad(err_paridad),
        .err_trama  (err_trama),
        .ocupado    (ocupado)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valida) begin
            n_val     = n_val + 1;
            last_dout = dout;
        end
        if (err_paridad) n_par = n_par + 1;
        if (err_trama)   n_tra = n_tra + 1;
        if ((32'(valida) + 32'(err_paridad) + 32'(err_trama)) > 1) n_multi = n_multi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        @(posedge clk);
        n_val = 0;
        n_par = 0;
        n_tra = 0;
    endtask

    // One PS/2 bit: data set while clock high, then a low half period.
    // last_lat records the first negedge (counted from the falling edge)
    // at which any output pulse is seen.
    task automatic send_bit(input logic b, input bit glitch);
        ps2d = b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            ps2c = 1'b0;
            repeat (3) @(negedge clk);
            ps2c = 1'b1;
            repeat (HALF/2 - 8) @(negedge clk);
        end else begin
            repeat (HALF/2) @(negedge clk);
        end
        ps2c = 1'b0;
        last_lat = 0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (last_lat == 0 && (valida || err_paridad || err_trama)) last_lat = k;
        end
        ps2c = 1'b1;
        repeat (HALF/2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit flip_par,
                              input logic stop, input bit glitch);
        send_bit(1'b0, glitch);
        ocup_mid = 32'(ocupado);
        for (int i = 0; i < 8; i++) send_bit(data[i], glitch);
        send_bit((~^data) ^ flip_par, glitch);
        send_bit(stop, glitch);
        ps2d = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] data, input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i], 1'b0);
        ps2d = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst  = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dout",    32'(dout),        32'h00);
        check("rst_valida",  32'(valida),      32'h0);
        check("rst_par",     32'(err_paridad), 32'h0);
        check("rst_trama",   32'(err_trama),   32'h0);
        check("rst_ocupado", 32'(ocupado),     32'h0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // 1: clean frame 0x1C
        clr_counts();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("t1_nval",    32'(n_val),     32'd1);
        check("t1_dout",    32'(last_dout), 32'h1C);
        check("t1_errs",    32'(n_par + n_tra), 32'd0);
        check("t1_lat",     32'(last_lat),  32'(EXP_LAT));
        check("t1_ocu_mid", 32'(ocup_mid),  32'd1);
        check("t1_ocu_end", 32'(ocupado),   32'd0);

        // 2: parity flipped
        clr_counts();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("t2_npar", 32'(n_par),    32'd1);
        check("t2_nval", 32'(n_val),    32'd0);
        check("t2_dout", 32'(dout),     32'h1C);
        check("t2_lat",  32'(last_lat), 32'(EXP_LAT));

        // 3: break sequence F0 1C swallowed, 32 delivered
        clr_counts();
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        check("t3_nval", 32'(n_val),     32'd1);
        check("t3_dout", 32'(last_dout), 32'h32);
        check("t3_errs", 32'(n_par + n_tra), 32'd0);

        // 3b: an error frame between F0 and the key keeps the flag; E0 passes
        clr_counts();
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        check("t3b_npar", 32'(n_par),     32'd1);
        check("t3b_nval", 32'(n_val),     32'd1);
        check("t3b_dout", 32'(last_dout), 32'hE0);

        // 4: partial frame then watchdog abort, then 0x2B
        clr_counts();
        send_partial(8'h2B, 3);
        check("t4_ocu_busy", 32'(ocupado), 32'd1);
        repeat (TIMEOUT + 10) @(negedge clk);
        check("t4_ntra",     32'(n_tra),   32'd1);
        check("t4_ocu_idle", 32'(ocupado), 32'd0);
        check("t4_nval0",    32'(n_val),   32'd0);
        clr_counts();
        send_frame(8'h2B, 1'b0, 1'b1, 1'b0);
        check("t4_nval", 32'(n_val),     32'd1);
        check("t4_dout", 32'(last_dout), 32'h2B);

        // 4b: stop bit 0 -> frame error, no delivery
        clr_counts();
        send_frame(8'h45, 1'b0, 1'b0, 1'b0);
        check("t4b_ntra", 32'(n_tra),    32'd1);
        check("t4b_nval", 32'(n_val + n_par), 32'd0);
        check("t4b_lat",  32'(last_lat), 32'(EXP_LAT));

        // 5: short glitches on ps2c during frame 0x5A
        clr_counts();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        check("t5_nval", 32'(n_val),     32'd1);
        check("t5_dout", 32'(last_dout), 32'h5A);
        check("t5_errs", 32'(n_par + n_tra), 32'd0);

        // 6: reset in the middle of a frame, then 0x23
        clr_counts();
        send_partial(8'h77, 5);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_rst_dout", 32'(dout),    32'h00);
        check("t6_rst_ocu",  32'(ocupado), 32'd0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_pulse", 32'(n_val + n_par + n_tra), 32'd0);
        clr_counts();
        send_frame(8'h23, 1'b0, 1'b1, 1'b0);
        check("t6_nval", 32'(n_val),     32'd1);
        check("t6_dout", 32'(last_dout), 32'h23);
        check("t6_errs", 32'(n_par + n_tra), 32'd0);

        check("one_hot_pulses", 32'(n_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
